fwd_scoreboard_mux: RTL and testbench
=====================================

Name: fwd_scoreboard_mux

Overview:
- Parametrised operand-forwarding block for the RISC-V pipeline. Generalises the fixed 3-way forwarding select to NUM_SRC source operands and DEPTH in-flight producer stages.
- Keeps an internal shift-register scoreboard of in-flight destination registers. Selects the youngest matching producer per operand.
- Raises a load-use stall when the youngest match has no data yet.
- Sits between register-file read (ID) and the EX operand inputs.

Parameters:
- XLEN, 32, operand/data width
- DEPTH, 3, number of tracked producer stages after ID (entry 0 = EX, 1 = MEM, 2 = WB)
- NUM_SRC, 2, number of source operands resolved per cycle
- LOAD_READY_STAGE, 2, first entry index at which a load's result is forwardable; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  instruction leaving ID this cycle
- issue_we_i  in  1  instruction writes rd
- issue_rd_i  in  5  destination register
- issue_is_load_i  in  1  instruction is a load
- flush_i  in  1  squash instructions in ID and EX (taken branch/jump)
- rs_i  in  NUM_SRC*5  source register indices, packed, src0 in LSBs
- rs_used_i  in  NUM_SRC  per-source "operand actually read" mask
- rf_data_i  in  NUM_SRC*XLEN  register-file read data
- stage_data_i  in  DEPTH*XLEN  result register of each tracked stage, entry 0 in LSBs
- op_o  out  NUM_SRC*XLEN  forwarded operands
- fwd_sel_o  out  NUM_SRC*SELW  per-source select: 0 = RF, k+1 = entry k; SELW = clog2(DEPTH+1)
- stall_o  out  1  hold PC/IF/ID, insert bubble into EX

Behaviour:
- Scoreboard state: DEPTH entries of {valid, we, rd[4:0], is_load}.
- Reset: on rising clk with rst=1, all entries are cleared (valid = 0). After reset, stall_o = 0, fwd_sel_o = 0, and op_o = rf_data_i. Reset asserted mid-operation behaves identically and discards all in-flight tracking.
- Every cycle when rst = 0:
  - entry[k] <= entry[k-1] for k = 1..DEPTH-1; the oldest entry falls off.
  - entry[0] <= issue fields, gated as valid = issue_valid_i & ~stall_o & ~flush_i.
- A stall inserts a bubble into entry[0] while older entries keep advancing.
- flush_i = 1:
  - entry[0] loads a bubble.
  - entry[1] loads a bubble instead of the old entry[0], squashing the EX instruction.
  - Flush has priority over stall.
- Entry readiness: an entry is ready when is_load = 0, or when k >= LOAD_READY_STAGE. This is purely positional and combinational.
- Match for source s: valid & we & (rd == rs_s) & (rs_s != 0).
- Forwarding (combinational, zero latency, per source):
  - rs_s == 0: op = rf_data_s, sel = 0. x0 is never forwarded.
  - Otherwise take the lowest k (youngest) with a match.
    - Match found and ready: op = stage_data[k], sel = k+1.
    - Match found but not ready: op = rf_data_s, sel = 0, source s raises a hazard.
    - No match: op = rf_data_s, sel = 0.
  - Older matches are never used when a younger match exists, even if the younger one is not ready.
- stall_o = OR over s of (hazard_s & rs_used_i[s]), then masked by ~flush_i. During a flush the ID instruction is dead, so no stall is raised.
- issue_* inputs are ignored while stall_o = 1; upstream holds them stable.
- LOAD_READY_STAGE = 0: loads never stall.
- rd = 0 writers occupy an entry but never match.
- Both sources matching the same entry: both forward from it independently.

Decomposition:
- Shared package fwd_pkg holds:
  - sb_entry_t typedef
  - SEL_RF = 0 constant
  - clog2-based SELW helper
- One sub-module fwd_prio_sel resolves a single source: priority match, readiness, data select.
- The top instantiates NUM_SRC copies of fwd_prio_sel plus the scoreboard shift register.

Test Plan:
- Reset: rst = 1 for 2 cycles, then rs = {1, 2} with no issue → stall_o = 0, fwd_sel_o = 0, op_o = rf_data_i.
- ALU back-to-back: issue add x5, then rs0 = 5 with stage_data[0] = 0xDEAD_BEEF → op0 = 0xDEADBEEF, sel0 = 1, no stall.
- Priority: x5 written in entry[0] and entry[1] (stage_data = 0x11, 0x22) → op0 = 0x11, sel0 = 1.
- Load-use (LOAD_READY_STAGE = 2):
  - Issue lw x7, then rs1 = 7, used → stall_o = 1 for exactly 2 cycles, with bubbles appearing in entry[0].
  - Third cycle: sel1 = 3, op1 = stage_data[2].
  - Same case with rs_used_i[1] = 0 → no stall.
- x0 / flush:
  - rs0 = 0 while an entry with rd = 0 exists → sel0 = 0.
  - flush_i during a load-use stall → stall_o = 0. Next cycle entries 0 and 1 are invalid and the load is gone: no further forward of x7.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
package fwd_pkg;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam int SEL_RF = 0;

  // One select code for the register file plus one per tracked stage.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Resolves one source operand: youngest matching producer, its readiness,
// and the resulting operand/select/hazard.
module fwd_prio_sel
  import fwd_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SELW             = 2
) (
  input  sb_entry_t [DEPTH-1:0]      entries,
  input  logic [4:0]                 rs,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [DEPTH*XLEN-1:0]      stage_data,
  output logic [XLEN-1:0]            op,
  output logic [SELW-1:0]            sel,
  output logic                       hazard
);

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] ready;
  logic             hit;
  logic             hit_ready;
  logic [XLEN-1:0]  hit_data;
  logic [SELW-1:0]  hit_sel;

  // x0 never matches, even against an rd = 0 writer.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = entries[k].valid & entries[k].we &
                 (entries[k].rd == rs) & (rs != 5'd0);
      ready[k] = ~entries[k].is_load | (k >= LOAD_READY_STAGE);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    hit_sel   = SELW'(SEL_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit       = 1'b1;
        hit_ready = ready[k];
        hit_data  = stage_data[k*XLEN +: XLEN];
        hit_sel   = SELW'(k + 1);
      end
    end
  end

  always_comb begin
    op     = rf_data;
    sel    = SELW'(SEL_RF);
    hazard = 1'b0;
    if (hit) begin
      if (hit_ready) begin
        op  = hit_data;
        sel = hit_sel;
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_mux.sv
// Operand forwarding between ID and EX: shift-register scoreboard of
// in-flight writers plus one priority selector per source operand.
module fwd_scoreboard_mux
  import fwd_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 3,
  parameter int NUM_SRC          = 2,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SELW            = sel_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  input  logic                      issue_we_i,
  input  logic [4:0]                issue_rd_i,
  input  logic                      issue_is_load_i,
  input  logic                      flush_i,
  input  logic [NUM_SRC*5-1:0]      rs_i,
  input  logic [NUM_SRC-1:0]        rs_used_i,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data_i,
  input  logic [DEPTH*XLEN-1:0]     stage_data_i,
  output logic [NUM_SRC*XLEN-1:0]   op_o,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
  output logic                      stall_o
);

  sb_entry_t [DEPTH-1:0] entries;
  logic [NUM_SRC-1:0]    hazard;
  logic                  stall;

  // A stalled or flushed ID slot enters as a bubble; flush also kills EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
    end else begin
      entries[0] <= '{valid:   issue_valid_i & ~stall & ~flush_i,
                      we:      issue_we_i,
                      rd:      issue_rd_i,
                      is_load: issue_is_load_i};
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= (k == 1 && flush_i) ? sb_entry_t'('0) : entries[k-1];
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_prio_sel #(
      .XLEN             (XLEN),
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SELW             (SELW)
    ) u_sel (
      .entries    (entries),
      .rs         (rs_i[s*5 +: 5]),
      .rf_data    (rf_data_i[s*XLEN +: XLEN]),
      .stage_data (stage_data_i),
      .op         (op_o[s*XLEN +: XLEN]),
      .sel        (fwd_sel_o[s*SELW +: SELW]),
      .hazard     (hazard[s])
    );
  end

  // The ID instruction is dead during a flush, so it never stalls.
  assign stall   = (|(hazard & rs_used_i)) & ~flush_i;
  assign stall_o = stall;

endmodule

// File: tb/tb_fwd_scoreboard_mux.sv
// Scoreboard-driven bench for fwd_scoreboard_mux at default parameters.
module tb_fwd_scoreboard_mux;

  localparam logic [31:0] RF0 = 32'hA0A0_A0A0;
  localparam logic [31:0] RF1 = 32'hB1B1_B1B1;

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_we, issue_is_load, flush;
  logic [4:0]  issue_rd, r0, r1;
  logic [1:0]  used;
  logic [31:0] sd0, sd1, sd2;
  logic [9:0]  rs;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [63:0] op;
  logic [3:0]  fwd_sel;
  logic        stall;

  exp_t expq[$];
  exp_t got, want;
  int   n_asserts = 0;
  int   n_fail    = 0;

  assign rs         = {r1, r0};
  assign rf_data    = {RF1, RF0};
  assign stage_data = {sd2, sd1, sd0};

  always #5 clk = ~clk;

  fwd_scoreboard_mux dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid),
    .issue_we_i      (issue_we),
    .issue_rd_i      (issue_rd),
    .issue_is_load_i (issue_is_load),
    .flush_i         (flush),
    .rs_i            (rs),
    .rs_used_i       (used),
    .rf_data_i       (rf_data),
    .stage_data_i    (stage_data),
    .op_o            (op),
    .fwd_sel_o       (fwd_sel),
    .stall_o         (stall)
  );

  function automatic exp_t mk(input logic [31:0] o0, input logic [31:0] o1,
                              input logic [1:0] s0, input logic [1:0] s1,
                              input logic st);
    return '{op0: o0, op1: o1, sel0: s0, sel1: s1, stall: st};
  endfunction

  function automatic exp_t observe();
    return {op[31:0], op[63:32], fwd_sel[1:0], fwd_sel[3:2], stall};
  endfunction

  task automatic set_in(input logic iv, input logic we, input logic [4:0] rd,
                        input logic ld, input logic fl, input logic [4:0] a,
                        input logic [4:0] b, input logic [1:0] u);
    issue_valid   = iv;
    issue_we      = we;
    issue_rd      = rd;
    issue_is_load = ld;
    flush         = fl;
    r0            = a;
    r1            = b;
    used          = u;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_in(1, 1, 5, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 2, 2'b11);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL reset_idle got=%h want=%h", got, want); end

    @(negedge clk);
    set_in(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 5, 0, 2'b01);
    sd0 = 32'h0000_5A5A;
    expq.push_back(mk(32'h0000_5A5A, RF1, 1, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL pre_reset_fwd got=%h want=%h", got, want); end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 5, 5, 2'b11);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL mid_reset_discard got=%h want=%h", got, want); end
  endtask

  task automatic test_alu_b2b();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 5, 3, 2'b11);
    sd0 = 32'hDEAD_BEEF;
    expq.push_back(mk(32'hDEAD_BEEF, RF1, 1, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL alu_b2b got=%h want=%h", got, want); end

    r1 = 5;
    expq.push_back(mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL both_same_entry got=%h want=%h", got, want); end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 5, 0, 2'b01);
    sd0 = 32'h11; sd1 = 32'h22; sd2 = 32'h33;
    expq.push_back(mk(32'h11, RF1, 1, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL prio_youngest got=%h want=%h", got, want); end

    @(negedge clk);
    expq.push_back(mk(32'h22, RF1, 2, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL prio_after_bubble got=%h want=%h", got, want); end

    do_reset();
    @(negedge clk);
    set_in(1, 1, 6, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(1, 1, 6, 1, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 6, 0, 2'b01);
    expq.push_back(mk(RF0, RF1, 0, 0, 1));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL younger_load_blocks got=%h want=%h", got, want); end
  endtask

  task automatic test_load_use();
    do_reset();
    sd0 = 32'h9999_0000; sd1 = 32'h2222_2222; sd2 = 32'h3333_3333;
    @(negedge clk);
    set_in(1, 1, 7, 1, 0, 0, 0, 0);
    // Consumer writes x9 and is held stable while stalled.
    @(negedge clk);
    set_in(1, 1, 9, 0, 0, 9, 7, 2'b10);
    expq.push_back(mk(RF0, RF1, 0, 0, 1));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL lu_stall_c1 got=%h want=%h", got, want); end

    @(negedge clk);
    expq.push_back(mk(RF0, RF1, 0, 0, 1));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL lu_stall_c2 got=%h want=%h", got, want); end

    @(negedge clk);
    expq.push_back(mk(RF0, 32'h3333_3333, 0, 3, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL lu_fwd_wb got=%h want=%h", got, want); end

    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 9, 0, 2'b01);
    expq.push_back(mk(32'h9999_0000, RF1, 1, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL lu_consumer_fwd got=%h want=%h", got, want); end

    do_reset();
    @(negedge clk);
    set_in(1, 1, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 7, 2'b00);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL lu_unused_no_stall got=%h want=%h", got, want); end
  endtask

  task automatic test_x0_flush();
    do_reset();
    sd0 = 32'h55; sd1 = 32'h66; sd2 = 32'h77;
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b11);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL x0_never_fwd got=%h want=%h", got, want); end

    do_reset();
    @(negedge clk);
    set_in(1, 1, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    set_in(1, 1, 9, 0, 1, 9, 7, 2'b10);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL flush_masks_stall got=%h want=%h", got, want); end

    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 9, 7, 2'b11);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL flush_squash got=%h want=%h", got, want); end

    @(negedge clk);
    expq.push_back(mk(RF0, RF1, 0, 0, 0));
    #2 got = observe(); want = expq.pop_front(); n_asserts++;
    if (got !== want) begin n_fail++; $display("[TB] FAIL flush_no_late_fwd got=%h want=%h", got, want); end
  endtask

  initial begin
    rst = 1'b1;
    sd0 = 32'h5D00_0000; sd1 = 32'h5D11_1111; sd2 = 32'h5D22_2222;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_b2b();
    test_priority();
    test_load_use();
    test_x0_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
